// File: rtl/nibble_add_sched_if.sv
// Bundle of the two requester ports, the adder-slice port and the result port.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready may depend on valid, never the reverse.
interface nibble_add_sched_if #(
    parameter int WORDS = 4
);
    localparam int W = 4 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic [3:0]   fa_a;
    logic [3:0]   fa_b;
    logic         fa_cin;
    logic [3:0]   fa_s;
    logic         fa_cout;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  fa_s, fa_cout, out_ready,
        output req0_ready, req1_ready,
        output fa_a, fa_b, fa_cin,
        output out_valid, out_sum, out_cout, out_id
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output fa_s, fa_cout, out_ready,
        input  req0_ready, req1_ready,
        input  fa_a, fa_b, fa_cin,
        input  out_valid, out_sum, out_cout, out_id
    );
endinterface

// File: rtl/nibble_add_sched.sv
// Round-robin sequencer sharing one external 4-bit adder slice between two requesters;
// operands are added one nibble per cycle, LSB first, with the carry held in a flop.
module nibble_add_sched #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_add_sched_if.slave bus,
    output logic [1:0]        dbg_state,
    output logic              dbg_prio
);
    localparam int W     = 4 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               id_q, id_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               gnt0, gnt1;
    logic               ready0, ready1;
    logic               out_valid;
    logic [3:0]         fa_a, fa_b;
    logic               fa_cin;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        id_d      = id_q;
        idx_d     = idx_q;
        ready0    = 1'b0;
        ready1    = 1'b0;
        out_valid = 1'b0;
        fa_a      = 4'd0;
        fa_b      = 4'd0;
        fa_cin    = 1'b0;

        // prio names the requester that wins a tie
        gnt0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ready0 = gnt0;
                    ready1 = gnt1;
                    if (gnt0 || gnt1) begin
                        a_d     = gnt1 ? bus.req1_a   : bus.req0_a;
                        b_d     = gnt1 ? bus.req1_b   : bus.req0_b;
                        carry_d = gnt1 ? bus.req1_cin : bus.req0_cin;
                        id_d    = gnt1;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    fa_a    = a_q[4*idx_q +: 4];
                    fa_b    = b_q[4*idx_q +: 4];
                    fa_cin  = carry_q;
                    sum_d[4*idx_q +: 4] = bus.fa_s;
                    carry_d = bus.fa_cout;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    out_valid = 1'b1;
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        prio_d  = ~id_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.fa_a       = fa_a;
    assign bus.fa_b       = fa_b;
    assign bus.fa_cin     = fa_cin;
    assign bus.out_valid  = out_valid;
    assign bus.out_sum    = sum_q;
    assign bus.out_cout   = carry_q;
    assign bus.out_id     = id_q;
    assign dbg_state      = state_q;
    assign dbg_prio       = prio_q;
endmodule

// File: tb/tb_nibble_add_sched.sv
// Bench for nibble_add_sched (WORDS=4) with a behavioural 4-bit adder slice,
// a vector table, hand-written corner sequences and a result scoreboard.
module tb_nibble_add_sched;
    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic       dbg_prio;

    int passed = 0;
    int total  = 0;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] sum_log[$];
    logic         cout_log[$];
    logic         id_log[$];

    logic [3:0] nib_a[WORDS];
    logic       nib_cin[WORDS];

    typedef struct {
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    nibble_add_sched_if #(.WORDS(WORDS)) bus ();

    nibble_add_sched #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio)
    );

    assign {bus.fa_cout, bus.fa_s} = {1'b0, bus.fa_a} + {1'b0, bus.fa_b} + {4'b0000, bus.fa_cin};

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // scoreboard: push on each accept, pop on each consumed result
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.req0_valid && bus.req0_ready)
                exp_q.push_back({1'b0, model_add(bus.req0_a, bus.req0_b, bus.req0_cin)});
            if (bus.req1_valid && bus.req1_ready)
                exp_q.push_back({1'b1, model_add(bus.req1_a, bus.req1_b, bus.req1_cin)});
            if (bus.out_valid && bus.out_ready) begin
                check("sb_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check("sb_result", {bus.out_id, bus.out_cout, bus.out_sum}, exp_q.pop_front());
                sum_log.push_back(bus.out_sum);
                cout_log.push_back(bus.out_cout);
                id_log.push_back(bus.out_id);
            end
        end
    end

    task automatic drive_req(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic v);
        if (sel) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = v;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = v;
        end
    endtask

    // one request end to end; leaves the bench at the first DONE cycle
    task automatic run_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input string name);
        logic rdy;
        @(negedge clk);
        drive_req(sel, a, b, cin, 1'b1);
        #1;
        rdy = sel ? bus.req1_ready : bus.req0_ready;
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk); #1;
            rdy = sel ? bus.req1_ready : bus.req0_ready;
        end
        check({name, "_accept"}, rdy, 1);
        @(posedge clk); #1;
        drive_req(sel, a, b, cin, 1'b0);
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk); #1;
            nib_a[i]   = bus.fa_a;
            nib_cin[i] = bus.fa_cin;
        end
        check({name, "_valid_early"}, bus.out_valid, 0);
        @(negedge clk); #1;
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_sum"},   bus.out_sum,   exp_sum);
        check({name, "_cout"},  bus.out_cout,  exp_cout);
        check({name, "_id"},    bus.out_id,    sel);
    endtask

    task automatic wait_out(input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_id,
                            input string name);
        int k;
        k = 0;
        @(negedge clk); #1;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_sum"},   bus.out_sum,   exp_sum);
        check({name, "_cout"},  bus.out_cout,  exp_cout);
        check({name, "_id"},    bus.out_id,    exp_id);
    endtask

    initial begin
        logic [3:0] exp_fa_a[WORDS];
        logic       exp_ids[4];
        logic       seen_valid;
        int         k;

        vecs[0] = '{1'b0, 16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[5] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        exp_fa_a = '{4'h3, 4'h0, 4'h0, 4'h0};
        exp_ids  = '{1'b0, 1'b1, 1'b0, 1'b1};

        // reset state, with a requester already asking
        rst = 1'b1;
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        bus.out_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_sum",    bus.out_sum,    0);
        check("rst_out_cout",   bus.out_cout,   0);
        check("rst_out_id",     bus.out_id,     0);
        check("rst_fa_a",       bus.fa_a,       0);
        check("rst_state",      dbg_state,      0);
        check("rst_prio",       dbg_prio,       0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // single request and nibble order
        run_op(1'b0, 16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, "single");
        for (int i = 0; i < WORDS; i++)
            check($sformatf("single_fa_a%0d", i), nib_a[i], exp_fa_a[i]);

        // carry rippling through every nibble
        run_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");
        for (int i = 0; i < WORDS; i++)
            check($sformatf("ripple_fa_cin%0d", i), nib_cin[i], 1);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                   $sformatf("vec%0d", i));

        // simultaneous requests after reset, then fairness over four operations
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sum_log.delete(); cout_log.delete(); id_log.delete();
        drive_req(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1);
        drive_req(1'b1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b1);
        k = 0;
        while (id_log.size() < 4 && k < 200) begin
            @(negedge clk); #3;
            k++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("fair_count", id_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_id%0d", i), id_log[i], exp_ids[i]);
        check("simul_sum0",  sum_log[0],  16'h5555);
        check("simul_cout0", cout_log[0], 0);
        check("simul_sum1",  sum_log[1],  16'h0000);
        check("simul_cout1", cout_log[1], 1);

        // backpressure in DONE while the other requester waits
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "bp");
        drive_req(1'b1, 16'h1357, 16'h2468, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("bp_hold_valid%0d", i), bus.out_valid, 1);
            check($sformatf("bp_hold_sum%0d", i),   bus.out_sum,   16'h0100);
            check($sformatf("bp_hold_id%0d", i),    bus.out_id,    0);
            check($sformatf("bp_hold_cout%0d", i),  bus.out_cout,  0);
            check($sformatf("bp_hold_rdy0_%0d", i), bus.req0_ready, 0);
            check($sformatf("bp_hold_rdy1_%0d", i), bus.req1_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_release_state", dbg_state, 0);
        check("bp_release_rdy1",  bus.req1_ready, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_out(16'h37C0, 1'b0, 1'b1, "bp_next");

        // reset in the middle of RUN
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "pre_rst");
        @(negedge clk); #1;
        check("prio_before_rst", dbg_prio, 1);
        drive_req(1'b0, 16'h0F00, 16'h0100, 1'b0, 1'b1);
        #1;
        check("midrun_accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("midrun_no_valid", seen_valid, 0);
        check("midrun_state",    dbg_state,  0);
        check("midrun_prio",     dbg_prio,   0);
        run_op(1'b1, 16'h000A, 16'h0006, 1'b0, 16'h0010, 1'b0, "post_rst");

        repeat (3) @(negedge clk);
        #3;
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nibble_add_sched.md
# nibble_add_sched

Sequencer and arbiter that shares a single external 4-bit ripple adder slice (`FA_4bit`: A, B, Cin -> S, Cout, purely combinational) between two requesters performing WORDS×4-bit additions. It accepts one operand pair at a time from requester 0 or 1 using round-robin arbitration. It feeds the slice one nibble per cycle, LSB first, with the carry registered between nibbles. It returns the full sum, carry-out and requester ID on a valid/ready output port.

## Interface
- WORDS, 4, number of nibbles per operand; operand width W = 4*WORDS; WORDS >= 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 accepted on this edge when req0_valid is also high.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- fa_a, fa_b  out  4  nibble operands driven to the adder slice.
- fa_cin  out  1  carry driven to the adder slice.
- fa_s  in  4  slice sum.
- fa_cout  in  1  slice carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  W  sum.
- out_cout  out  1  final carry-out.
- out_id  out  1  ID of the requester that issued this result.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Grant when only one valid is high: that requester.
  - Grant when both are high: the requester named by priority pointer `prio`; reset value of `prio` is 0.
  - reqN_ready is high only for the granted requester, and only in IDLE.
  - On acceptance, latch a, b, id; load the carry register with cin; idx <= 0; go to RUN.
- **RUN**
  - fa_a = a_reg[4*idx+3:4*idx], fa_b = b_reg nibble idx, fa_cin = carry_reg.
  - Each edge: sum_reg nibble idx <= fa_s; carry_reg <= fa_cout; idx++.
  - After the nibble idx = WORDS-1 capture, go to DONE.
  - requester inputs are ignored; both readys are low.
- **DONE**
  - out_valid = 1; out_sum = sum_reg, out_cout = carry_reg, out_id = id_reg, all held stable.
  - On out_valid && out_ready: go to IDLE and set prio <= ~id_reg, which favours the other requester.
- Outside RUN, fa_a, fa_b and fa_cin drive 0.
- Arithmetic: {out_cout, out_sum} = a + b + cin, computed modulo 2^(W+1) exactly.
- Readys may depend combinationally on the valids. Requesters must not make valid depend on ready.
- Reset values: state IDLE, prio 0, out_valid 0, out_sum 0, out_cout 0, out_id 0, req0_ready/req1_ready 0 during reset, fa_* 0.
- Reset mid-RUN or mid-DONE aborts the operation. No result is emitted and the in-flight request is lost.

## Timing
- Accept edge T (valid && ready): RUN drives nibbles 0..WORDS-1 in cycles T+1..T+WORDS.
- out_valid is high from cycle T+WORDS+1. Latency is WORDS+1 cycles.
- out_ready high in the first DONE cycle: IDLE in the next cycle, and the next accept is possible in that cycle. Minimum spacing between accepts is WORDS+2 cycles.
- out_ready low: DONE is held indefinitely, with outputs stable and no accepts.
- A valid deasserted before acceptance is dropped silently. No request is latched without a handshake.

## Test plan
All scenarios use WORDS=4. The slice is modelled as a behavioural 4-bit adder.
- **Single request:** req0 a=0x0003, b=0x0001, cin=0 -> out_valid at T+5; sum=0x0004, cout=0, id=0; fa_a sequence 3,0,0,0.
- **Full ripple:** req1 a=0xFFFF, b=0x0000, cin=1 -> fa_cin sequence 1,1,1,1; sum=0x0000, cout=1, id=1.
- **Simultaneous after reset:** req0 0x1234+0x4321+0 and req1 0xA5A5+0x5A5B+0 both valid -> first result 0x5555/cout0/id0, then 0x0000/cout1/id1.
- **Backpressure:** hold out_ready=0 for 3 cycles in DONE -> out_sum/out_cout/out_id stable, both readys 0, no accept; release -> IDLE the next cycle.
- **Fairness:** both valids held high for 4 operations -> out_id sequence 0,1,0,1, each sum correct.
- **Reset mid-RUN:** assert rst at T+2 -> no out_valid, state IDLE, prio 0; a subsequent req1 0x000A+0x0006+0 -> 0x0010, cout 0, id 1.
